// File: rtl/decrip_stream_pkg.sv
// Shared definitions for the 3-bit -> 5-bit substitution code link.
// Holds the code table (used by both the encryptor and decryptor) and the
// receive-side link-health state encoding.
package decrip_stream_pkg;

    // Code emitted by the encryptor for each 3-bit symbol value
    localparam logic [4:0] CODE_0 = 5'd7;
    localparam logic [4:0] CODE_1 = 5'd1;
    localparam logic [4:0] CODE_2 = 5'd9;
    localparam logic [4:0] CODE_3 = 5'd6;
    localparam logic [4:0] CODE_4 = 5'd10;
    localparam logic [4:0] CODE_5 = 5'd11;
    localparam logic [4:0] CODE_6 = 5'd20;
    localparam logic [4:0] CODE_7 = 5'd8;

    // Link health: waiting for first good code, normal, too many bad codes
    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    // Forward mapping, for the encryption side
    function automatic logic [4:0] encrypt_sym(input logic [2:0] sym);
        logic [4:0] code;
        case (sym)
            3'd0:    code = CODE_0;
            3'd1:    code = CODE_1;
            3'd2:    code = CODE_2;
            3'd3:    code = CODE_3;
            3'd4:    code = CODE_4;
            3'd5:    code = CODE_5;
            3'd6:    code = CODE_6;
            default: code = CODE_7;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/decrip_lut.sv
// Inverse substitution table: 5-bit code -> 3-bit symbol.
// Codes outside the table report o_inv=1 with a zero symbol.
module decrip_lut
    import decrip_stream_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [2:0] o_sym,
    output logic       o_inv
);

    // Table lookup; anything not listed is an invalid code
    always_comb begin
        o_sym = 3'd0;
        o_inv = 1'b0;
        case (i_code)
            CODE_0:  o_sym = 3'd0;
            CODE_1:  o_sym = 3'd1;
            CODE_2:  o_sym = 3'd2;
            CODE_3:  o_sym = 3'd3;
            CODE_4:  o_sym = 3'd4;
            CODE_5:  o_sym = 3'd5;
            CODE_6:  o_sym = 3'd6;
            CODE_7:  o_sym = 3'd7;
            default: o_inv = 1'b1;
        endcase
    end

endmodule

// File: rtl/decrip_stream.sv
// Receive-side decryptor for the substitution-coded symbol link.
// Valid/ready input, one registered output stage, SYNC/RUN/ALARM link
// health tracking and a saturating count of invalid codes.
module decrip_stream
    import decrip_stream_pkg::*;
#(
    parameter int ERR_LIM  = 3,
    parameter int GOOD_LIM = 2,
    parameter int CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       ECRi,
    input  logic             ECRi_vld,
    output logic             ECRi_rdy,
    output logic [2:0]       Dout,
    output logic             Dout_vld,
    input  logic             Dout_rdy,
    output logic             Derr,
    output logic             ALARM,
    output logic [CNT_W-1:0] ERRCNT
);

    localparam logic [3:0]       ERR_LIM_4  = 4'(ERR_LIM);
    localparam logic [3:0]       GOOD_LIM_4 = 4'(GOOD_LIM);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_bad_run, w_bad_nxt, w_bad_inc;
    logic [3:0]       r_good_run, w_good_nxt, w_good_inc;
    logic [CNT_W-1:0] r_errcnt, w_errcnt_nxt, w_errcnt_sat;
    logic [2:0]       r_dout;
    logic             r_derr;
    logic             r_dvld;
    logic [2:0]       w_sym;
    logic             w_inv;
    logic             w_acc;
    logic             w_emit;

    decrip_lut u_lut (
        .i_code (ECRi),
        .o_sym  (w_sym),
        .o_inv  (w_inv)
    );

    // Output slot is free when empty or being drained this cycle
    assign ECRi_rdy     = !RST && (!r_dvld || Dout_rdy);
    assign w_acc        = ECRi_vld && ECRi_rdy;
    assign w_bad_inc    = r_bad_run + 4'd1;
    assign w_good_inc   = r_good_run + 4'd1;
    assign w_errcnt_sat = (r_errcnt == CNT_MAX) ? r_errcnt : r_errcnt + CNT_ONE;

    // Next state, run counters and error count, advanced only on accepted codes
    always_comb begin
        w_state_nxt  = r_state;
        w_bad_nxt    = r_bad_run;
        w_good_nxt   = r_good_run;
        w_errcnt_nxt = r_errcnt;
        w_emit       = 1'b0;
        if (w_acc) begin
            case (r_state)
                ST_SYNC: begin
                    // Bad codes before lock are silently swallowed
                    if (!w_inv) begin
                        w_emit      = 1'b1;
                        w_state_nxt = ST_RUN;
                        w_bad_nxt   = 4'd0;
                        w_good_nxt  = 4'd0;
                    end
                end
                ST_RUN: begin
                    w_emit = 1'b1;
                    if (w_inv) begin
                        w_errcnt_nxt = w_errcnt_sat;
                        if (w_bad_inc == ERR_LIM_4) begin
                            w_state_nxt = ST_ALARM;
                            w_bad_nxt   = 4'd0;
                            w_good_nxt  = 4'd0;
                        end else begin
                            w_bad_nxt = w_bad_inc;
                        end
                    end else begin
                        w_bad_nxt = 4'd0;
                    end
                end
                ST_ALARM: begin
                    w_emit = 1'b1;
                    if (w_inv) begin
                        w_errcnt_nxt = w_errcnt_sat;
                        w_good_nxt   = 4'd0;
                    end else if (w_good_inc == GOOD_LIM_4) begin
                        w_state_nxt = ST_RUN;
                        w_bad_nxt   = 4'd0;
                        w_good_nxt  = 4'd0;
                    end else begin
                        w_good_nxt = w_good_inc;
                    end
                end
                default: w_state_nxt = ST_SYNC;
            endcase
        end
    end

    // State register and counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_SYNC;
            r_bad_run  <= 4'd0;
            r_good_run <= 4'd0;
            r_errcnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bad_run  <= w_bad_nxt;
            r_good_run <= w_good_nxt;
            r_errcnt   <= w_errcnt_nxt;
        end
    end

    // Output register: load a new result, else release on consume, else hold
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dvld <= 1'b0;
            r_dout <= 3'd0;
            r_derr <= 1'b0;
        end else if (w_emit) begin
            r_dvld <= 1'b1;
            r_dout <= w_sym;
            r_derr <= w_inv;
        end else if (r_dvld && Dout_rdy) begin
            r_dvld <= 1'b0;
        end
    end

    assign Dout     = r_dout;
    assign Dout_vld = r_dvld;
    assign Derr     = r_derr;
    assign ALARM    = (r_state == ST_ALARM);
    assign ERRCNT   = r_errcnt;

endmodule

// File: tb/tb_decrip_stream.sv
// Bench for decrip_stream: directed vector table, hand-written stall/reset
// sequences, and a randomized stream against a transaction-level model.
module tb_decrip_stream;

    localparam int ERR_LIM  = 3;
    localparam int GOOD_LIM = 2;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [4:0]       ECRi = 5'd0;
    logic             ECRi_vld = 1'b0;
    logic             ECRi_rdy;
    logic [2:0]       Dout;
    logic             Dout_vld;
    logic             Dout_rdy = 1'b1;
    logic             Derr;
    logic             ALARM;
    logic [CNT_W-1:0] ERRCNT;

    always #5 CLK = ~CLK;

    decrip_stream #(.ERR_LIM(ERR_LIM), .GOOD_LIM(GOOD_LIM), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ECRi(ECRi), .ECRi_vld(ECRi_vld), .ECRi_rdy(ECRi_rdy),
        .Dout(Dout), .Dout_vld(Dout_vld), .Dout_rdy(Dout_rdy), .Derr(Derr),
        .ALARM(ALARM), .ERRCNT(ERRCNT)
    );

    int total = 0;
    int bad   = 0;

    // Symbol i is sent as code_tbl[i]
    int code_tbl[8] = '{7, 1, 9, 6, 10, 11, 20, 8};

    // Reference model of the link receiver
    bit m_vld, m_derr;
    int m_dout, m_err, m_mode, m_bad, m_good, m_emits;
    int obs_cons;
    bit last_acc;

    function automatic int lookup(input int code);
        for (int i = 0; i < 8; i++)
            if (code_tbl[i] == code) return i;
        return -1;
    endfunction

    function automatic int rand_inv();
        int c;
        do c = int'($urandom_range(0, 31)); while (lookup(c) >= 0);
        return c;
    endfunction

    function automatic void model_reset();
        m_vld = 0; m_derr = 0; m_dout = 0; m_err = 0;
        m_mode = 0; m_bad = 0; m_good = 0;
    endfunction

    function automatic bit exp_rdy(input bit rst, input bit rdy);
        return !rst && (!m_vld || rdy);
    endfunction

    // mode: 0 = waiting for lock, 1 = running, 2 = alarmed
    function automatic void model_step(input bit rst, input bit vld, input int code, input bit rdy);
        bit acc, emit, inv;
        int s;
        if (rst) begin
            model_reset();
            return;
        end
        acc = vld && exp_rdy(rst, rdy);
        if (m_vld && rdy) m_vld = 0;
        if (!acc) return;
        s = lookup(code);
        inv = (s < 0);
        emit = 1;
        if (m_mode == 0) begin
            if (inv) emit = 0;
            else begin m_mode = 1; m_bad = 0; m_good = 0; end
        end else if (inv) begin
            if (m_err < CNT_MAX) m_err++;
            if (m_mode == 1) begin
                m_bad++;
                if (m_bad == ERR_LIM) begin m_mode = 2; m_bad = 0; m_good = 0; end
            end else begin
                m_good = 0;
            end
        end else begin
            if (m_mode == 1) m_bad = 0;
            else begin
                m_good++;
                if (m_good == GOOD_LIM) begin m_mode = 1; m_bad = 0; m_good = 0; end
            end
        end
        if (emit) begin
            m_vld = 1; m_derr = inv; m_dout = inv ? 0 : s; m_emits++;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check ready, clock, check all outputs vs model
    task automatic cyc(input bit rst, input bit vld, input int code, input bit rdy);
        RST = rst; ECRi_vld = vld; ECRi = 5'(code); Dout_rdy = rdy;
        #1;
        chk("ecri_rdy", {31'd0, ECRi_rdy}, {31'd0, exp_rdy(rst, rdy)});
        last_acc = vld && exp_rdy(rst, rdy);
        if (!rst && Dout_vld && Dout_rdy) obs_cons++;
        @(posedge CLK);
        model_step(rst, vld, code, rdy);
        #1;
        chk("dout_vld", {31'd0, Dout_vld}, {31'd0, m_vld});
        chk("dout",     {29'd0, Dout},     m_dout);
        chk("derr",     {31'd0, Derr},     {31'd0, m_derr});
        chk("alarm",    {31'd0, ALARM},    {31'd0, (m_mode == 2)});
        chk("errcnt",   {24'd0, ERRCNT},   m_err);
    endtask

    // Offer one word until taken, with random downstream back-pressure
    task automatic send(input int code);
        int tries = 0;
        do begin
            cyc(0, 1, code, $urandom_range(0, 3) != 0);
            tries++;
        end while (!last_acc && tries < 20);
        chk("send_accept", {31'd0, last_acc}, 1);
    endtask

    typedef struct {
        bit rst_first;
        int code;
        bit vld;
        int dout;
        bit derr;
        bit alarm;
        int errcnt;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int inv_sent, emits0, cons0;

        // lock-up stream, dropped pre-lock codes, error run into and out of alarm
        vecs[0]  = '{1,  7, 1, 0, 0, 0, 0};
        vecs[1]  = '{0,  1, 1, 1, 0, 0, 0};
        vecs[2]  = '{0,  9, 1, 2, 0, 0, 0};
        vecs[3]  = '{0,  6, 1, 3, 0, 0, 0};
        vecs[4]  = '{0, 10, 1, 4, 0, 0, 0};
        vecs[5]  = '{0, 11, 1, 5, 0, 0, 0};
        vecs[6]  = '{0, 20, 1, 6, 0, 0, 0};
        vecs[7]  = '{0,  8, 1, 7, 0, 0, 0};
        vecs[8]  = '{1,  0, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 31, 0, 0, 0, 0, 0};
        vecs[10] = '{0,  9, 1, 2, 0, 0, 0};
        vecs[11] = '{0,  5, 1, 0, 1, 0, 1};
        vecs[12] = '{0, 12, 1, 0, 1, 0, 2};
        vecs[13] = '{0, 13, 1, 0, 1, 1, 3};
        vecs[14] = '{0,  7, 1, 0, 0, 1, 3};
        vecs[15] = '{0,  1, 1, 1, 0, 0, 3};

        model_reset();
        m_emits = 0; obs_cons = 0; last_acc = 0;
        @(posedge CLK); #1;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst_first) begin
                cyc(1, 0, 0, 1);
                cyc(1, 0, 0, 1);
                chk("rst_vld",    {31'd0, Dout_vld}, 0);
                chk("rst_errcnt", {24'd0, ERRCNT},   0);
            end
            cyc(0, 1, vecs[i].code, 1);
            chk("vec_vld",    {31'd0, Dout_vld}, {31'd0, vecs[i].vld});
            chk("vec_dout",   {29'd0, Dout},     vecs[i].dout);
            chk("vec_derr",   {31'd0, Derr},     {31'd0, vecs[i].derr});
            chk("vec_alarm",  {31'd0, ALARM},    {31'd0, vecs[i].alarm});
            chk("vec_errcnt", {24'd0, ERRCNT},   vecs[i].errcnt);
        end

        // Stall: result 6 held while 8 waits, then simultaneous consume/accept
        cyc(0, 1, 20, 1);
        chk("stall_load", {29'd0, Dout}, 6);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 8, 0);
            chk("stall_dout", {29'd0, Dout},     6);
            chk("stall_vld",  {31'd0, Dout_vld}, 1);
            chk("stall_rdy",  {31'd0, ECRi_rdy}, 0);
        end
        cyc(0, 1, 8, 1);
        chk("release_dout", {29'd0, Dout},     7);
        chk("release_vld",  {31'd0, Dout_vld}, 1);
        cyc(0, 0, 0, 1);
        chk("drain_vld", {31'd0, Dout_vld}, 0);

        // Error count saturation with alarm toggling; every result accounted for
        emits0 = m_emits; cons0 = obs_cons;
        send(code_tbl[$urandom_range(0, 7)]);
        inv_sent = 0;
        while (inv_sent < 300) begin
            int nb = int'($urandom_range(1, 4));
            int ng = int'($urandom_range(1, 3));
            for (int j = 0; j < nb && inv_sent < 300; j++) begin
                send(rand_inv());
                inv_sent++;
            end
            for (int j = 0; j < ng; j++) send(code_tbl[$urandom_range(0, 7)]);
        end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("sat_errcnt", {24'd0, ERRCNT}, CNT_MAX);
        chk("no_loss", obs_cons - cons0, m_emits - emits0);
        send(rand_inv());
        send(rand_inv());
        cyc(0, 0, 0, 1);
        chk("sat_hold", {24'd0, ERRCNT}, CNT_MAX);

        // Reset while alarmed with a held result
        for (int j = 0; j < ERR_LIM; j++) cyc(0, 1, rand_inv(), 1);
        cyc(0, 0, 0, 0);
        chk("pre_rst_alarm", {31'd0, ALARM},    1);
        chk("pre_rst_vld",   {31'd0, Dout_vld}, 1);
        cyc(1, 1, 3, 1);
        chk("rst_dout",   {29'd0, Dout},     0);
        chk("rst_vld2",   {31'd0, Dout_vld}, 0);
        chk("rst_derr",   {31'd0, Derr},     0);
        chk("rst_alarm",  {31'd0, ALARM},    0);
        chk("rst_errcnt2",{24'd0, ERRCNT},   0);
        cyc(0, 1, 3, 1);
        chk("sync_drop", {31'd0, Dout_vld}, 0);
        cyc(0, 1, 6, 1);
        chk("sync_lock_vld",  {31'd0, Dout_vld}, 1);
        chk("sync_lock_dout", {29'd0, Dout},     3);

        // Random traffic, occasional reset
        for (int n = 0; n < 2000; n++) begin
            bit r = ($urandom_range(0, 199) == 0);
            int c = ($urandom_range(0, 1) != 0) ? code_tbl[$urandom_range(0, 7)]
                                                : int'($urandom_range(0, 31));
            cyc(r, $urandom_range(0, 3) != 0, c, $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
